mul_div_seq_unit: RTL and testbench

//  Iterative RV32M/RV64M multiply/divide unit in the EX stage. Executes all eight M-extension ops.

---
 rtl/mul_div_defs.sv | 21 ++
 rtl/mul_div_seq_unit.sv | 140 ++++++++++++++
 tb/tb_mul_div_seq_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_defs.sv
// Shared encodings for the iterative M-extension unit: funct3 op codes and FSM states.
package mul_div_defs;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_DONE    = 2'd2
  } state_e;

endpackage

// File: rtl/mul_div_seq_unit.sv
// Iterative RV32M/RV64M multiply/divide unit. One radix-2 iteration per cycle on
// operand magnitudes; signs are re-applied when the last iteration completes.
// Divide-by-zero and signed divide overflow are answered without iterating.
module mul_div_seq_unit
  import mul_div_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] operand_a,
  input  logic [XLEN-1:0] operand_b,
  input  logic            flush,
  output logic [XLEN-1:0] result,
  output logic            busy,
  output logic            ready
);

  localparam int CNT_W = $clog2(XLEN) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

  state_e                state, state_nxt;
  op_e                   op_q;
  logic [XLEN-1:0]       b_mag, quo, rem, result_q;
  logic [2*XLEN-1:0]     acc;
  logic                  neg_q, neg_r;
  logic [CNT_W-1:0]      counter;

  op_e                   op_in;
  logic                  a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0]       a_mag_in, b_mag_in, special_res, final_res;
  logic                  div_zero, div_ovf, special, launch, last_iter;
  logic [XLEN:0]         mul_sum, div_shift, div_diff;
  logic                  div_ok;
  logic [2*XLEN-1:0]     acc_nxt, prod;
  logic [XLEN-1:0]       quo_nxt, rem_nxt, quo_fix, rem_fix;

  assign op_in = op_e'(op);

  // Operand decode at launch: magnitudes, signs and the non-iterating divide cases.
  always_comb begin
    a_signed = (op_in == OP_MULH) || (op_in == OP_MULHSU) ||
               (op_in == OP_DIV)  || (op_in == OP_REM);
    b_signed = (op_in == OP_MULH) || (op_in == OP_DIV) || (op_in == OP_REM);
    a_neg    = a_signed & operand_a[XLEN-1];
    b_neg    = b_signed & operand_b[XLEN-1];
    a_mag_in = a_neg ? -operand_a : operand_a;
    b_mag_in = b_neg ? -operand_b : operand_b;
    div_zero = op[2] && (operand_b == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (operand_a == MIN_VAL) && (operand_b == '1);
    special  = div_zero || div_ovf;
    // op[1] separates REM/REMU from DIV/DIVU
    special_res = '0;
    if (div_zero)     special_res = op[1] ? operand_a : '1;
    else if (div_ovf) special_res = op[1] ? '0 : MIN_VAL;
  end

  assign launch    = (state == ST_IDLE) && start && !flush;
  assign last_iter = (state == ST_COMPUTE) && !flush && (counter == LAST_CNT);

  // One shift-add and one restoring-divide step, plus the sign fixup of the final values.
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
    acc_nxt   = {mul_sum, acc[XLEN-1:1]};
    // partial remainder stays below 2*b_mag, so XLEN+1 bits hold the signed difference
    div_shift = {rem, quo[XLEN-1]};
    div_diff  = div_shift - {1'b0, b_mag};
    div_ok    = ~div_diff[XLEN];
    rem_nxt   = div_ok ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
    quo_nxt   = {quo[XLEN-2:0], div_ok};
    prod      = neg_q ? -acc_nxt : acc_nxt;
    quo_fix   = neg_q ? -quo_nxt : quo_nxt;
    rem_fix   = neg_r ? -rem_nxt : rem_nxt;
    if (op_q[2])              final_res = op_q[1] ? rem_fix : quo_fix;
    else if (op_q == OP_MUL)  final_res = prod[XLEN-1:0];
    else                      final_res = prod[2*XLEN-1:XLEN];
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; flush beats start in IDLE and aborts COMPUTE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (launch) state_nxt = special ? ST_DONE : ST_COMPUTE;
      end
      ST_COMPUTE: begin
        if (flush)                     state_nxt = ST_IDLE;
        else if (counter == LAST_CNT)  state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: load magnitudes at launch, iterate in COMPUTE, capture the result at the end.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      op_q     <= OP_MUL;
      b_mag    <= '0;
      acc      <= '0;
      quo      <= '0;
      rem      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      counter  <= '0;
      result_q <= '0;
    end else if (launch) begin
      op_q     <= op_in;
      b_mag    <= b_mag_in;
      acc      <= {{XLEN{1'b0}}, a_mag_in};
      quo      <= a_mag_in;
      rem      <= '0;
      neg_q    <= a_neg ^ b_neg;
      neg_r    <= a_neg;
      counter  <= '0;
      if (special) result_q <= special_res;
    end else if (state == ST_COMPUTE) begin
      acc     <= acc_nxt;
      quo     <= quo_nxt;
      rem     <= rem_nxt;
      counter <= counter + 1'b1;
      if (last_iter) result_q <= final_res;
    end
  end

  assign result = result_q;
  assign busy   = (state == ST_COMPUTE);
  assign ready  = (state == ST_DONE);

endmodule

// File: tb/tb_mul_div_seq_unit.sv
// Self-checking bench for mul_div_seq_unit (XLEN=32): directed RISC-V M cases,
// control-path corner cases and randomized ops against an arithmetic reference model.
module tb_mul_div_seq_unit;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            start;
  logic [2:0]      op;
  logic [XLEN-1:0] operand_a, operand_b;
  logic            flush;
  logic [XLEN-1:0] result;
  logic            busy, ready;

  int n_tests = 0;
  int n_fail  = 0;
  bit hold_start = 1'b0;

  mul_div_seq_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op),
    .operand_a(operand_a), .operand_b(operand_b), .flush(flush),
    .result(result), .busy(busy), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic following the RISC-V M definitions.
  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    logic [63:0] ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (o)
      3'd0: p = ua * ub;
      3'd1: begin p = sa * sb; p = p >> 32; end
      3'd2: begin p = sa * $signed(ub); p = p >> 32; end
      3'd3: begin p = ua * ub; p = p >> 32; end
      3'd4: begin
        if (b == 0) p = '1;
        else if (a == MINV && b == 32'hFFFF_FFFF) p = {32'b0, MINV};
        else p = sa / sb;
      end
      3'd5: p = (b == 0) ? '1 : ua / ub;
      3'd6: begin
        if (b == 0) p = ua;
        else if (a == MINV && b == 32'hFFFF_FFFF) p = '0;
        else p = sa % sb;
      end
      default: p = (b == 0) ? ua : ua % ub;
    endcase
    return p[31:0];
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
    return o[2] && ((b == 0) || ((o == 3'd4 || o == 3'd6) && a == MINV && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return MINV;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Launch one op, follow it to its ready pulse, check latency, busy length and result.
  // Returns at the falling edge inside the DONE cycle.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp);
    int lat, busy_cnt;
    bit sp;
    sp = is_special(o, a, b);
    @(negedge clk);
    start = 1'b1; op = o; operand_a = a; operand_b = b;
    @(negedge clk);
    start = hold_start; op = 3'($urandom); operand_a = $urandom; operand_b = $urandom;
    lat = 0; busy_cnt = 0;
    for (int n = 1; n <= XLEN + 4; n++) begin
      if (busy && ready) chk({tag, " busy&ready"}, 1, 0);
      if (busy) busy_cnt++;
      if (ready) begin
        lat = n;
        break;
      end
      @(negedge clk);
    end
    chk({tag, " latency"}, lat, sp ? 1 : XLEN + 1);
    chk({tag, " busy cycles"}, busy_cnt, sp ? 0 : XLEN);
    chk({tag, " result"}, result, exp);
  endtask

  task automatic count_ready(input int cycles, output int cnt);
    cnt = 0;
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      if (ready) cnt++;
    end
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  o;
    logic [31:0] a, b, exp;
  } vec_t;

  vec_t vecs[$];
  int   cnt;
  logic [2:0]  ro;
  logic [31:0] ra, rb;

  initial begin
    reset_n = 1'b0; start = 1'b0; op = '0; operand_a = '0; operand_b = '0; flush = 1'b0;
    #12;
    chk("reset busy", busy, 0);
    chk("reset ready", ready, 0);
    chk("reset result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;

    vecs.push_back('{"MUL 7*-3",        3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{"MULH min*min",    3'd1, MINV,         MINV,          32'h4000_0000});
    vecs.push_back('{"MULHU min*min",   3'd3, MINV,         MINV,          32'h4000_0000});
    vecs.push_back('{"MULHSU -1*2",     3'd2, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF});
    vecs.push_back('{"DIV -7/2",        3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD});
    vecs.push_back('{"REM -7/2",        3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF});
    vecs.push_back('{"DIVU 100/7",      3'd5, 32'd100,      32'd7,         32'd14});
    vecs.push_back('{"REMU 100/7",      3'd7, 32'd100,      32'd7,         32'd2});
    vecs.push_back('{"DIV 5/0",         3'd4, 32'd5,        32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"REM 5/0",         3'd6, 32'd5,        32'd0,         32'd5});
    vecs.push_back('{"DIVU 5/0",        3'd5, 32'd5,        32'd0,         32'hFFFF_FFFF});
    vecs.push_back('{"REMU 9/0",        3'd7, 32'd9,        32'd0,         32'd9});
    vecs.push_back('{"DIV ovf",         3'd4, MINV,         32'hFFFF_FFFF, MINV});
    vecs.push_back('{"REM ovf",         3'd6, MINV,         32'hFFFF_FFFF, 32'd0});
    vecs.push_back('{"DIVU min/-1",     3'd5, MINV,         32'hFFFF_FFFF, 32'd0});
    foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].o, vecs[i].a, vecs[i].b, vecs[i].exp);

    // flush at the 10th COMPUTE cycle aborts without a ready pulse
    @(negedge clk);
    start = 1'b1; op = 3'd1; operand_a = 32'h1234_5678; operand_b = 32'h0BAD_F00D;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int n = 0; n < 40; n++) begin
      if (busy) cnt++;
      if (cnt == 10) break;
      @(negedge clk);
    end
    chk("flush reached 10 busy", cnt, 10);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush busy", busy, 0);
    chk("flush ready", ready, 0);
    count_ready(40, cnt);
    chk("flush no ready", cnt, 0);
    run_op("MULHU 3*5 after flush", 3'd3, 32'd3, 32'd5, 32'd0);

    // start and flush together in IDLE: no launch (special case would answer at T+1)
    @(negedge clk);
    start = 1'b1; flush = 1'b1; op = 3'd4; operand_a = 32'd5; operand_b = 32'd0;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    chk("start+flush busy", busy, 0);
    chk("start+flush ready", ready, 0);
    count_ready(XLEN + 4, cnt);
    chk("start+flush no ready", cnt, 0);

    // flush during DONE: ready still pulses, unit returns to IDLE
    run_op("DIVU before done-flush", 3'd5, 32'd1000, 32'd3, 32'd333);
    flush = 1'b1;
    #1;
    chk("done-flush ready", ready, 1);
    @(negedge clk);
    flush = 1'b0;
    chk("after done-flush busy", busy, 0);
    chk("after done-flush ready", ready, 0);

    // start held through busy and DONE: exactly one ready pulse
    hold_start = 1'b1;
    run_op("MUL held start", 3'd0, 32'd123, 32'd456, 32'd56088);
    hold_start = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("held start idle busy", busy, 0);
    count_ready(XLEN + 4, cnt);
    chk("held start extra ready", cnt, 0);

    // asynchronous reset in the middle of COMPUTE
    @(negedge clk);
    start = 1'b1; op = 3'd5; operand_a = 32'd77; operand_b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre-reset busy", busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("async reset busy", busy, 0);
    chk("async reset ready", ready, 0);
    chk("async reset result", result, 0);
    @(negedge clk);
    reset_n = 1'b1;
    count_ready(XLEN + 4, cnt);
    chk("after reset no ready", cnt, 0);

    // randomized ops against the reference model
    for (int i = 0; i < 250; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = rand_operand();
      rb = rand_operand();
      run_op($sformatf("rand%0d op%0d a=%0h b=%0h", i, ro, ra, rb), ro, ra, rb,
             ref_model(ro, ra, rb));
    end

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
